// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_pkg
//  Description : Shared types and defaults for the fabric configuration
//                loader: FSM state encoding, default sync bytes, default
//                prog bus width and the IO-switch slice width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cfg_pkg;

   // Loader FSM states
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SYNC1  = 3'd1,
      S_LOAD   = 3'd2,
      S_CHECK  = 3'd3,
      S_COMMIT = 3'd4
   } cfg_state_t;

   localparam logic [7:0] SYNC0_DEF    = 8'hA5;
   localparam logic [7:0] SYNC1_DEF    = 8'h5A;
   localparam int         PROG_W_DEF   = 4480;
   localparam int         IOSW_SLICE_W = 16;

endpackage : cfg_pkg
`default_nettype wire

// File: rtl/cfg_bitstream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_bitstream_loader
//  Description : Writer side of the fabric programming interface. Hunts for a
//                two-byte sync word on a byte-wide valid/ready stream, shifts
//                PROG_W/8 payload bytes into the prog bus (first byte ends up
//                in the MSBs), checks a trailing XOR checksum and, on a match,
//                pulses prog_en for EN_CYC cycles so the fabric latches prog.
//  Ports       : clb_clk   - clock, rising edge
//                rst_n     - asynchronous active-low reset
//                cfg_data  - configuration byte
//                cfg_valid - cfg_data valid
//                cfg_ready - loader accepts a byte (low only while committing)
//                prog      - assembled configuration word
//                prog_en   - commit strobe, EN_CYC cycles wide
//                busy      - frame in progress (sync1/load/check/commit)
//                done      - sticky, last frame committed
//                err       - sticky, last frame failed its checksum
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_bitstream_loader
   import cfg_pkg::*;
#(
   parameter int         PROG_W = PROG_W_DEF,
   parameter logic [7:0] SYNC0  = SYNC0_DEF,
   parameter logic [7:0] SYNC1  = SYNC1_DEF,
   parameter int         EN_CYC = 1
)(
   input  logic              clb_clk,
   input  logic              rst_n,
   input  logic [7:0]        cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic [PROG_W-1:0] prog,
   output logic              prog_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int NBYTES = PROG_W / 8;
   localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(NBYTES - 1);
   // prog_en stays high for c_EN_LAST+1 cycles
   localparam logic [3:0]       c_EN_LAST  = 4'(EN_CYC - 1);

   cfg_state_t        r_state;
   logic [PROG_W-1:0] r_prog;
   logic [CNT_W-1:0]  r_byte_cnt;
   logic [7:0]        r_csum;
   logic [3:0]        r_en_cnt;
   logic              r_prog_en;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              r_ready;

   logic              w_xfer;

   assign w_xfer = cfg_valid & r_ready;

   // All outputs are registered and updated together with the state so they
   // always reflect the state the FSM is in.
   always_ff @(posedge clb_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_prog     <= '0;
         r_byte_cnt <= '0;
         r_csum     <= '0;
         r_en_cnt   <= '0;
         r_prog_en  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_ready    <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_xfer && cfg_data == SYNC0) begin
                  r_state <= S_SYNC1;
                  r_busy  <= 1'b1;
               end
            end

            S_SYNC1: begin
               if (w_xfer) begin
                  if (cfg_data == SYNC1) begin
                     r_state    <= S_LOAD;
                     r_done     <= 1'b0;
                     r_err      <= 1'b0;
                     r_byte_cnt <= '0;
                     r_csum     <= '0;
                  end else if (cfg_data != SYNC0) begin
                     // A repeated SYNC0 keeps hunting; anything else aborts
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end

            S_LOAD: begin
               if (w_xfer) begin
                  r_prog <= {r_prog[PROG_W-9:0], cfg_data};
                  r_csum <= r_csum ^ cfg_data;
                  // Counter saturates at the last index instead of wrapping
                  if (r_byte_cnt == c_LAST_IDX) begin
                     r_state <= S_CHECK;
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                  end
               end
            end

            S_CHECK: begin
               if (w_xfer) begin
                  if (cfg_data == r_csum) begin
                     r_state   <= S_COMMIT;
                     r_prog_en <= 1'b1;
                     r_ready   <= 1'b0;
                     r_en_cnt  <= c_EN_LAST;
                  end else begin
                     r_state <= S_IDLE;
                     r_err   <= 1'b1;
                     r_busy  <= 1'b0;
                  end
               end
            end

            S_COMMIT: begin
               if (r_en_cnt == 4'd0) begin
                  r_state   <= S_IDLE;
                  r_prog_en <= 1'b0;
                  r_done    <= 1'b1;
                  r_ready   <= 1'b1;
                  r_busy    <= 1'b0;
               end else begin
                  r_en_cnt <= r_en_cnt - 1'b1;
               end
            end

            default: begin
               r_state   <= S_IDLE;
               r_prog_en <= 1'b0;
               r_ready   <= 1'b1;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready = r_ready;
   assign prog      = r_prog;
   assign prog_en   = r_prog_en;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

endmodule : cfg_bitstream_loader
`default_nettype wire

// File: tb/tb_cfg_bitstream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfg_bitstream_loader
//  Description : Self-checking bench for cfg_bitstream_loader. Expected prog
//                contents and checksums come from a byte-array model of the
//                frame payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_bitstream_loader;

   localparam int PROG_W = 4480;
   localparam int NB     = PROG_W / 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [PROG_W-1:0] prog;
   logic              prog_en;
   logic              busy;
   logic              done;
   logic              err;

   always #5 clk = ~clk;

   cfg_bitstream_loader #(
      .PROG_W (PROG_W),
      .SYNC0  (8'hA5),
      .SYNC1  (8'h5A),
      .EN_CYC (1)
   ) dut (
      .clb_clk   (clk),
      .rst_n     (rst_n),
      .cfg_data  (cfg_data),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .prog      (prog),
      .prog_en   (prog_en),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   int         errors = 0;
   int         checks = 0;
   logic [7:0] pl [NB];
   bit         gaps = 1'b0;
   int         en_cycles = 0;
   int         ready_viol = 0;

   // With EN_CYC=1, commit is exactly the cycle prog_en is high, and that is
   // the only time cfg_ready may be low.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prog_en) en_cycles++;
         if (cfg_ready == prog_en) ready_viol++;
      end
   end

   function automatic logic [PROG_W-1:0] exp_prog();
      logic [PROG_W-1:0] e;
      e = '0;
      for (int i = 0; i < NB; i++) e[PROG_W-1-8*i -: 8] = pl[i];
      return e;
   endfunction

   function automatic logic [7:0] exp_csum();
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < NB; i++) c = c ^ pl[i];
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_prog(input string tag);
      logic [PROG_W-1:0] e;
      int                idx;
      e = exp_prog();
      checks++;
      assert (prog === e) else begin
         errors++;
         idx = 0;
         for (int i = NB - 1; i >= 0; i--)
            if (prog[PROG_W-1-8*i -: 8] !== e[PROG_W-1-8*i -: 8]) idx = i;
         $error("FAIL %s: byte %0d observed=%02h expected=%02h", tag, idx,
                prog[PROG_W-1-8*idx -: 8], e[PROG_W-1-8*idx -: 8]);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the transfer edge.
   task automatic send_byte(input logic [7:0] b);
      int t;
      int g;
      if (gaps) begin
         g = 0;
         while ($urandom_range(1, 0) == 1 && g < 8) begin
            cfg_valid = 1'b0;
            @(negedge clk);
            g++;
         end
      end
      cfg_data  = b;
      cfg_valid = 1'b1;
      t = 0;
      while (!cfg_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!cfg_ready) begin
         checks++;
         errors++;
         $error("FAIL ready_timeout: observed=0 expected=1");
      end
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] cs);
      send_byte(8'hA5);
      send_byte(8'h5A);
      for (int i = 0; i < NB; i++) send_byte(pl[i]);
      send_byte(cs);
   endtask

   task automatic fill_const(input logic [7:0] v);
      for (int i = 0; i < NB; i++) pl[i] = v;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < NB; i++) pl[i] = 8'($urandom);
   endtask

   // Runs right after the checksum byte of a good frame was accepted.
   task automatic commit_checks(input string tag);
      check({tag, "_prog_en_rise"}, {31'd0, prog_en}, 32'd1);
      check({tag, "_ready_low"},    {31'd0, cfg_ready}, 32'd0);
      @(negedge clk);
      check({tag, "_prog_en_fall"}, {31'd0, prog_en}, 32'd0);
      check({tag, "_done"},         {31'd0, done}, 32'd1);
      check({tag, "_err"},          {31'd0, err}, 32'd0);
      check({tag, "_busy"},         {31'd0, busy}, 32'd0);
      check({tag, "_en_cycles"},    en_cycles, 32'd1);
      check_prog({tag, "_prog"});
   endtask

   initial begin
      logic [7:0] bad;

      // ---------------- reset ----------------
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_prog_zero", {31'd0, |prog}, 32'd0);
      check("rst_prog_en",   {31'd0, prog_en}, 32'd0);
      check("rst_busy",      {31'd0, busy}, 32'd0);
      check("rst_done",      {31'd0, done}, 32'd0);
      check("rst_err",       {31'd0, err}, 32'd0);
      check("rst_ready",     {31'd0, cfg_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // ---------------- 1: full frame of 01 ----------------
      fill_const(8'h01);
      en_cycles  = 0;
      ready_viol = 0;
      check("t1_csum_model", {24'd0, exp_csum()}, 32'h00);
      send_frame(exp_csum());
      commit_checks("t1");

      // ---------------- 2: bad checksum ----------------
      en_cycles = 0;
      send_frame(8'hFF);
      check("t2_err",       {31'd0, err}, 32'd1);
      check("t2_done",      {31'd0, done}, 32'd0);
      check("t2_busy",      {31'd0, busy}, 32'd0);
      check("t2_ready",     {31'd0, cfg_ready}, 32'd1);
      repeat (2) @(negedge clk);
      check("t2_en_cycles", en_cycles, 32'd0);
      check_prog("t2_prog_kept");

      // ---------------- 3: sync hunt ----------------
      fill_rand();
      en_cycles = 0;
      send_byte(8'h00);
      send_byte(8'hA5);
      send_frame(exp_csum());
      commit_checks("t3a");

      fill_rand();
      en_cycles = 0;
      send_byte(8'hA5);
      send_byte(8'h33);
      check("t3b_idle_busy", {31'd0, busy}, 32'd0);
      send_frame(exp_csum());
      commit_checks("t3b");

      // ---------------- 4: byte ordering ----------------
      fill_const(8'h00);
      pl[0]     = 8'hC3;
      en_cycles = 0;
      send_frame(8'hC3);
      commit_checks("t4");
      check("t4_msb_byte", {24'd0, prog[PROG_W-1 -: 8]}, 32'hC3);
      check("t4_lsb_byte", {24'd0, prog[7:0]}, 32'h00);

      // ---------------- random payload, corrupted checksum ----------------
      fill_rand();
      en_cycles = 0;
      bad = 8'($urandom_range(255, 1));
      send_frame(exp_csum() ^ bad);
      check("tr_err",  {31'd0, err}, 32'd1);
      check("tr_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("tr_en_cycles", en_cycles, 32'd0);
      check_prog("tr_prog_kept");

      // ---------------- 5: random valid gaps ----------------
      fill_const(8'h01);
      gaps      = 1'b1;
      en_cycles = 0;
      send_frame(exp_csum());
      commit_checks("t5");
      gaps = 1'b0;
      check("t5_ready_only_in_commit", ready_viol, 32'd0);

      // ---------------- 6: reset mid-frame ----------------
      fill_rand();
      send_byte(8'hA5);
      send_byte(8'h5A);
      for (int i = 0; i < 300; i++) send_byte(pl[i]);
      check("t6_busy_mid", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_prog",    {31'd0, |prog}, 32'd0);
      check("t6_rst_prog_en", {31'd0, prog_en}, 32'd0);
      check("t6_rst_busy",    {31'd0, busy}, 32'd0);
      check("t6_rst_done",    {31'd0, done}, 32'd0);
      check("t6_rst_err",     {31'd0, err}, 32'd0);
      check("t6_rst_ready",   {31'd0, cfg_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fill_rand();
      en_cycles = 0;
      send_frame(exp_csum());
      commit_checks("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_cfg_bitstream_loader
`default_nettype wire
